// File: rtl/window_sweeper.sv
// window_sweeper: multi-scale sliding-window address generator.
// Per frame it walks every enabled scale, every window origin (stride
// STRIDE_X/STRIDE_Y, bounded per scale) and every pixel of each window.
// It emits scaled coordinates together with scale and window tags.
//
// Stream handshake: a point transfers on a cycle where addr_valid and
// addr_ready are both high at the rising clock edge. Once addr_valid is
// raised it stays high, and every output stays stable, until that point
// transfers. The counters advance only on a transfer.
module window_sweeper #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int WIN_X      = 24,
    parameter int WIN_Y      = 24,
    parameter int STRIDE_X   = 1,
    parameter int STRIDE_Y   = 1,
    parameter int SCALE_NUM  = 4,
    parameter int FRAC_W     = 16,
    localparam int RW        = FRAC_W + 6,
    localparam int W_X       = $clog2(IMG_WIDTH),
    localparam int W_Y       = $clog2(IMG_HEIGHT),
    localparam int W_S       = (SCALE_NUM > 1) ? $clog2(SCALE_NUM) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W_S:0]   num_scales,
    output logic           busy,
    output logic           done,
    input  logic           cfg_we,
    input  logic [W_S-1:0] cfg_idx,
    input  logic [RW-1:0]  cfg_ratio,
    input  logic [W_X-1:0] cfg_bound_x,
    input  logic [W_Y-1:0] cfg_bound_y,
    output logic           addr_valid,
    input  logic           addr_ready,
    output logic [W_X-1:0] x,
    output logic [W_Y-1:0] y,
    output logic [W_S-1:0] scale,
    output logic           win_first,
    output logic           win_last,
    output logic           frame_last
);

    localparam int PXW = W_X + 1 + RW;
    localparam int PYW = W_Y + 1 + RW;
    localparam logic [W_X-1:0] WX_LAST    = W_X'(WIN_X - 1);
    localparam logic [W_Y-1:0] WY_LAST    = W_Y'(WIN_Y - 1);
    localparam logic [RW-1:0]  RATIO_ONE  = RW'(64'd1 << FRAC_W);
    localparam logic [W_X-1:0] DEF_BX     = W_X'(IMG_WIDTH - WIN_X);
    localparam logic [W_Y-1:0] DEF_BY     = W_Y'(IMG_HEIGHT - WIN_Y);
    localparam logic [W_X-1:0] X_MAX      = W_X'(IMG_WIDTH - 1);
    localparam logic [W_Y-1:0] Y_MAX      = W_Y'(IMG_HEIGHT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         r_state;
    logic           r_busy;
    logic           r_done;
    logic           r_valid;
    logic [W_X-1:0] r_wx;
    logic [W_Y-1:0] r_wy;
    logic [W_X-1:0] r_hop_x;
    logic [W_Y-1:0] r_hop_y;
    logic [W_S-1:0] r_scale;
    logic [W_S-1:0] r_scale_last;

    logic [RW-1:0]  r_ratio   [SCALE_NUM];
    logic [W_X-1:0] r_bound_x [SCALE_NUM];
    logic [W_Y-1:0] r_bound_y [SCALE_NUM];

    logic           w_hs;
    logic           w_wx_last;
    logic           w_wy_last;
    logic           w_hx_last;
    logic           w_hy_last;
    logic           w_scale_last;
    logic           w_win_last;
    logic           w_frame_last;
    logic [W_S-1:0] w_ns_m1;
    logic [W_X:0]   w_sum_x;
    logic [W_Y:0]   w_sum_y;
    logic [PXW-1:0] w_prod_x;
    logic [PYW-1:0] w_prod_y;
    logic [PXW-1:0] w_sc_x;
    logic [PYW-1:0] w_sc_y;

    // Loop-end detection and next-origin legality for the current point.
    always_comb begin
        w_hs         = r_valid & addr_ready;
        w_wx_last    = (r_wx == WX_LAST);
        w_wy_last    = (r_wy == WY_LAST);
        w_hx_last    = (32'(r_hop_x) + 32'(STRIDE_X)) > 32'(r_bound_x[r_scale]);
        w_hy_last    = (32'(r_hop_y) + 32'(STRIDE_Y)) > 32'(r_bound_y[r_scale]);
        w_scale_last = (r_scale == r_scale_last);
        w_win_last   = w_wx_last & w_wy_last;
        w_frame_last = w_win_last & w_hx_last & w_hy_last & w_scale_last;
    end

    // Requested scale count mapped to a last-scale index (0 -> 1, clamp high).
    always_comb begin
        w_ns_m1 = '0;
        if (num_scales == '0) begin
            w_ns_m1 = '0;
        end else if (32'(num_scales) > SCALE_NUM) begin
            w_ns_m1 = W_S'(SCALE_NUM - 1);
        end else begin
            w_ns_m1 = W_S'(num_scales - (W_S + 1)'(1));
        end
    end

    // Scaled coordinates: full-width product, floor, saturate to the image.
    always_comb begin
        w_sum_x  = {1'b0, r_hop_x} + {1'b0, r_wx};
        w_sum_y  = {1'b0, r_hop_y} + {1'b0, r_wy};
        w_prod_x = PXW'(w_sum_x) * PXW'(r_ratio[r_scale]);
        w_prod_y = PYW'(w_sum_y) * PYW'(r_ratio[r_scale]);
        w_sc_x   = w_prod_x >> FRAC_W;
        w_sc_y   = w_prod_y >> FRAC_W;
        x        = (w_sc_x > PXW'(X_MAX)) ? X_MAX : w_sc_x[W_X-1:0];
        y        = (w_sc_y > PYW'(Y_MAX)) ? Y_MAX : w_sc_y[W_Y-1:0];
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign addr_valid = r_valid;
    assign scale      = r_scale;
    assign win_first  = (r_wx == '0) & (r_wy == '0);
    assign win_last   = w_win_last;
    assign frame_last = w_frame_last;

    // Frame FSM: nested window/origin/scale counters stepped per transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_valid      <= 1'b0;
            r_wx         <= '0;
            r_wy         <= '0;
            r_hop_x      <= '0;
            r_hop_y      <= '0;
            r_scale      <= '0;
            r_scale_last <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_busy       <= 1'b1;
                        r_valid      <= 1'b1;
                        r_wx         <= '0;
                        r_wy         <= '0;
                        r_hop_x      <= '0;
                        r_hop_y      <= '0;
                        r_scale      <= '0;
                        r_scale_last <= w_ns_m1;
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        if (!w_wx_last) begin
                            r_wx <= r_wx + W_X'(1);
                        end else begin
                            r_wx <= '0;
                            if (!w_wy_last) begin
                                r_wy <= r_wy + W_Y'(1);
                            end else begin
                                r_wy <= '0;
                                if (!w_hx_last) begin
                                    r_hop_x <= r_hop_x + W_X'(STRIDE_X);
                                end else begin
                                    r_hop_x <= '0;
                                    if (!w_hy_last) begin
                                        r_hop_y <= r_hop_y + W_Y'(STRIDE_Y);
                                    end else begin
                                        r_hop_y <= '0;
                                        if (!w_scale_last) begin
                                            r_scale <= r_scale + W_S'(1);
                                        end else begin
                                            r_scale <= '0;
                                            r_state <= S_IDLE;
                                            r_busy  <= 1'b0;
                                            r_valid <= 1'b0;
                                            r_done  <= 1'b1;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Scale table: writable only while idle, out-of-range indices ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SCALE_NUM; i++) begin
                r_ratio[i]   <= RATIO_ONE;
                r_bound_x[i] <= DEF_BX;
                r_bound_y[i] <= DEF_BY;
            end
        end else if (cfg_we && (r_state == S_IDLE) && (32'(cfg_idx) < SCALE_NUM)) begin
            r_ratio[cfg_idx]   <= cfg_ratio;
            r_bound_x[cfg_idx] <= cfg_bound_x;
            r_bound_y[cfg_idx] <= cfg_bound_y;
        end
    end

endmodule
